fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
Sequencer that runs one 18x36 MAC unit as an NTAPS-tap direct-form FIR filter.
- Holds the sample delay line (circular buffer).
- Reads coefficients from an external synchronous coefficient ROM.
- Clears the MAC through its synchronous reset, streams NTAPS operand pairs, waits out the MAC pipeline, then captures the 68-bit result.
- Sits between the sample source and the MAC; one output per accepted sample.

Parameters:
NTAPS, 16, number of taps (≥2)
ADDR_W, 4, coefficient address width = clog2(NTAPS)
MAC_LAT, 4, cycles from last operand presented to final MAC_OUT valid

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
sample_in  in  18  signed input sample
sample_valid  in  1  sample_in valid this cycle
sample_ready  out  1  high in IDLE; a sample is accepted when sample_valid && sample_ready
overrun  out  1  one-cycle pulse: sample_valid seen while sample_ready low (sample dropped)
coef_addr  out  ADDR_W  coefficient ROM address
coef_data  in  36  signed coefficient, valid one cycle after coef_addr
mac_clr  out  1  drives the MAC's synchronous reset
mac_a  out  18  signed MAC operand A (sample)
mac_b  out  36  signed MAC operand B (coefficient)
mac_out  in  68  signed MAC accumulator output
y_out  out  68  captured filter output
y_valid  out  1  one-cycle pulse, y_out updated
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any time, including mid-operation):
  - State returns to IDLE; write pointer wr_ptr=0; all NTAPS buffer entries = 0.
  - Outputs: y_out=0, y_valid=0, overrun=0, mac_clr=1, mac_a=0, mac_b=0, coef_addr=0.
- FSM: IDLE -> CLEAR -> RUN -> DRAIN -> IDLE.
- Cycle numbering: cycle 0 is the cycle in which the sample is accepted in IDLE.
- IDLE:
  - mac_clr=0, mac_a=0, mac_b=0.
  - On accept, write buf[wr_ptr]=sample_in and go to CLEAR.
- CLEAR (cycle 1):
  - mac_clr=1; coef_addr=0.
  - tap counter k=0; rd_ptr=wr_ptr, i.e. the newest sample.
- RUN (cycles 2..NTAPS+1, k=0..NTAPS-1):
  - mac_a=buf[rd_ptr], mac_b=coef_data (coefficient k); coef_addr=k+1 (don't-care on the last tap).
  - rd_ptr decrements modulo NTAPS.
  - After k=NTAPS-1, go to DRAIN.
- DRAIN (cycles NTAPS+2..NTAPS+1+MAC_LAT):
  - mac_a=0, mac_b=0 so the free-running accumulators add nothing.
  - On the last DRAIN cycle: y_out<=mac_out, y_valid<=1, wr_ptr<=wr_ptr+1 mod NTAPS, state<=IDLE.
- Output timing:
  - y_valid is high in cycle NTAPS+2+MAC_LAT, which is also the first IDLE cycle.
  - Maximum throughput: one sample per NTAPS+2+MAC_LAT cycles.
- Computation: y(n) = sum over k=0..NTAPS-1 of c[k]·x(n-k), full 68-bit signed precision, no rounding or saturation.
- Overflow: the MAC wraps at 68 bits.
- Overrun: a sample_valid while busy is ignored. overrun pulses in the following cycle; operation in progress is unaffected.
- Outside RUN, mac_a and mac_b are held at 0.
- Simultaneous sample_valid and y_valid (first IDLE cycle): the sample is accepted normally.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, CLEAR, RUN, DRAIN (2 bits).
  - Widths: SAMPLE_W=18, COEF_W=36, ACC_W=68.
  - Default MAC_LAT=4.
- One sub-module: fir_sample_ring.
  - NTAPS x 18 register file with asynchronous clear.
  - Write port; combinational read port addressed by rd_ptr.

Test Plan:
- Impulse, NTAPS=4, coefs {1,2,3,4}:
  - Stimulus: sample 1, then three 0 samples, then one more 0.
  - Required: y_out = 1, 2, 3, 4, 0.
  - First y_valid exactly 10 cycles after accept.
- Bit-17 coefficient:
  - Stimulus: coefs {0x20000,0,0,0}, sample 3.
  - Required: y_out=393216.
  - Stimulus: coef {0x3FFFF,0,0,0}, sample -1.
  - Required: y_out=-262143.
- Signed extremes:
  - Stimulus: coef 0x800000000 (-2^35), sample -131072.
  - Required: y_out=+2^52.
  - Stimulus: coef 0x7FFFFFFFF, sample 131071.
  - Required: y_out=(2^35-1)·(2^17-1).
- Overrun:
  - Stimulus: sample_valid held high continuously.
  - Required: accepts exactly every 10 cycles (NTAPS=4).
  - overrun pulses on each dropped cycle.
  - Outputs match only the accepted samples.
- Reset mid-RUN:
  - Stimulus: assert reset at tap k=2.
  - Required: immediate IDLE, mac_clr=1, no y_valid.
  - Next impulse produces 1, 2, 3, 4 with the buffer cleared.
- Wrap-around:
  - Stimulus: 2·NTAPS+1 ramp samples 1..9, coefs {1,1,1,1}.
  - Required: steady-state y_out = sum of last 4 samples (e.g. 30 for x=9..6).

Source files
------------

// File: rtl/fir_mac_sequencer_pkg.sv
// Shared types and widths for the FIR MAC sequencer.
// The MAC itself is external; these widths describe its operands and accumulator.
package fir_mac_sequencer_pkg;

  localparam int unsigned SAMPLE_W        = 18;
  localparam int unsigned COEF_W          = 36;
  localparam int unsigned ACC_W           = 68;
  localparam int unsigned MAC_LAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StRun   = 2'd2,
    StDrain = 2'd3
  } state_e;

endpackage

// File: rtl/fir_sample_ring.sv
// Sample delay line: NTAPS-entry register file, one write port and one
// combinational read port. Asynchronous reset clears every entry.
module fir_sample_ring
  import fir_mac_sequencer_pkg::*;
#(
  parameter int unsigned NTAPS  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem_q [NTAPS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Runs an external 18x36 MAC as an NTAPS-tap direct-form FIR: accept a sample,
// clear the MAC, stream NTAPS operand pairs, wait out the MAC latency, capture.
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int unsigned NTAPS   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned MAC_LAT = MAC_LAT_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                overrun,
  output logic [ADDR_W-1:0]   coef_addr,
  input  logic [COEF_W-1:0]   coef_data,
  output logic                mac_clr,
  output logic [SAMPLE_W-1:0] mac_a,
  output logic [COEF_W-1:0]   mac_b,
  input  logic [ACC_W-1:0]    mac_out,
  output logic [ACC_W-1:0]    y_out,
  output logic                y_valid,
  output logic                busy
);

  localparam int unsigned CNT_MAX = (NTAPS > MAC_LAT) ? NTAPS : MAC_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W-1:0] LastPtr   = ADDR_W'(NTAPS - 1);
  localparam logic [CNT_W-1:0]  LastTap   = CNT_W'(NTAPS - 1);
  localparam logic [CNT_W-1:0]  LastDrain = CNT_W'(MAC_LAT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    y_out_q;
  logic                y_valid_q, overrun_q, mac_clr_q;
  logic [SAMPLE_W-1:0] rd_sample;
  logic                accept, done;

  fir_sample_ring #(
    .NTAPS  (NTAPS),
    .ADDR_W (ADDR_W)
  ) u_ring (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (accept),
    .wr_addr (wr_ptr_q),
    .wr_data (sample_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_sample)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    accept       = 1'b0;
    done         = 1'b0;
    sample_ready = 1'b0;
    busy         = 1'b1;
    coef_addr    = '0;
    mac_a        = '0;
    mac_b        = '0;
    unique case (state_q)
      StIdle: begin
        sample_ready = 1'b1;
        busy         = 1'b0;
        if (sample_valid) begin
          accept   = 1'b1;
          rd_ptr_d = wr_ptr_q;
          state_d  = StClear;
        end
      end
      StClear: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        // ROM is one cycle behind its address, so present the next tap's address now
        mac_a     = rd_sample;
        mac_b     = coef_data;
        coef_addr = ADDR_W'(cnt_q + 1'b1);
        rd_ptr_d  = (rd_ptr_q == '0) ? LastPtr : rd_ptr_q - 1'b1;
        if (cnt_q == LastTap) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == LastDrain) begin
          done     = 1'b1;
          wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
          cnt_d    = '0;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      mac_clr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      y_valid_q <= done;
      if (done) begin
        y_out_q <= mac_out;
      end
      overrun_q <= sample_valid & ~sample_ready;
      mac_clr_q <= (state_d == StClear);
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;
  assign overrun = overrun_q;
  assign mac_clr = mac_clr_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with NTAPS=4: behavioural ROM and MAC,
// expected filter outputs queued at stimulus time and popped on y_valid.
module tb_fir_mac_sequencer;

  localparam int unsigned NTAPS   = 4;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned MAC_LAT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic [1:0]  coef_addr;
  logic [35:0] coef_data;
  logic        mac_clr;
  logic [17:0] mac_a;
  logic [35:0] mac_b;
  logic [67:0] mac_out;
  logic [67:0] y_out;
  logic        y_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [67:0] exp_q[$];
  logic [67:0] mon_exp;
  logic [35:0] rom [NTAPS];
  logic [67:0] p0, p1, p2, acc;

  always #5 clock = ~clock;

  fir_mac_sequencer #(
    .NTAPS   (NTAPS),
    .ADDR_W  (ADDR_W),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .mac_clr      (mac_clr),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_out      (mac_out),
    .y_out        (y_out),
    .y_valid      (y_valid),
    .busy         (busy)
  );

  always_ff @(posedge clock) coef_data <= rom[coef_addr];

  // MAC model: operand presented in cycle t reaches mac_out in cycle t+4
  always_ff @(posedge clock) begin
    if (mac_clr) begin
      p0  <= '0;
      p1  <= '0;
      p2  <= '0;
      acc <= '0;
    end else begin
      p0  <= {{50{mac_a[17]}}, mac_a} * {{32{mac_b[35]}}, mac_b};
      p1  <= p0;
      p2  <= p1;
      acc <= acc + p2;
    end
  end
  assign mac_out = acc;

  always @(negedge clock) begin
    if (y_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL y_unexpected observed %0d expected no output", $signed(y_out));
      end else begin
        mon_exp = exp_q.pop_front();
        assert (y_out === mon_exp) else begin
          errors++;
          $error("FAIL y_out observed %0d expected %0d", $signed(y_out), $signed(mon_exp));
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rom(input logic [35:0] c0, input logic [35:0] c1,
                         input logic [35:0] c2, input logic [35:0] c3);
    rom[0] = c0;
    rom[1] = c1;
    rom[2] = c2;
    rom[3] = c3;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Drive one sample in an idle cycle; returns 1 time unit into cycle 1.
  task automatic send(input logic [17:0] x, input bit push, input logic [67:0] e);
    sample_in    = x;
    sample_valid = 1'b1;
    @(negedge clock);
    chk("ready_on_send", 68'(sample_ready), 68'(1));
    if (push) exp_q.push_back(e);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 40) begin
      tick();
      n++;
    end
    chk("drain_pending", 68'(exp_q.size()), 68'(0));
  endtask

  initial begin
    logic [67:0] ramp_exp [9];
    logic [67:0] ovr_exp [4];
    ramp_exp = '{68'd1, 68'd3, 68'd6, 68'd10, 68'd14, 68'd18, 68'd22, 68'd26, 68'd30};
    ovr_exp  = '{68'd100, 68'd310, 68'd640, 68'd1100};

    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    set_rom(36'd1, 36'd2, 36'd3, 36'd4);

    // Reset state
    @(negedge clock);
    chk("rst_y_out", y_out, 68'(0));
    chk("rst_y_valid", 68'(y_valid), 68'(0));
    chk("rst_overrun", 68'(overrun), 68'(0));
    chk("rst_mac_clr", 68'(mac_clr), 68'(1));
    chk("rst_mac_a", 68'(mac_a), 68'(0));
    chk("rst_mac_b", 68'(mac_b), 68'(0));
    chk("rst_coef_addr", 68'(coef_addr), 68'(0));
    chk("rst_busy", 68'(busy), 68'(0));
    chk("rst_ready", 68'(sample_ready), 68'(1));
    tick();
    reset = 1'b0;
    tick();

    // Impulse with exact latency: accept in cycle 0, y_valid in cycle 10
    send(18'd1, 1'b1, 68'd1);
    @(negedge clock);
    chk("clear_mac_clr", 68'(mac_clr), 68'(1));
    chk("clear_busy", 68'(busy), 68'(1));
    tick();
    @(negedge clock);
    chk("run0_mac_a", 68'(mac_a), 68'(1));
    chk("run0_mac_b", 68'(mac_b), 68'(1));
    chk("run0_coef_addr", 68'(coef_addr), 68'(1));
    chk("run0_mac_clr", 68'(mac_clr), 68'(0));
    repeat (4) tick();
    @(negedge clock);
    chk("drain_mac_a", 68'(mac_a), 68'(0));
    chk("drain_mac_b", 68'(mac_b), 68'(0));
    repeat (3) tick();
    @(negedge clock);
    chk("lat_cycle9_no_valid", 68'(y_valid), 68'(0));
    tick();
    @(negedge clock);
    chk("lat_cycle10_valid", 68'(y_valid), 68'(1));
    chk("lat_cycle10_ready", 68'(sample_ready), 68'(1));
    wait_done();
    send(18'd0, 1'b1, 68'd2); wait_done();
    send(18'd0, 1'b1, 68'd3); wait_done();
    send(18'd0, 1'b1, 68'd4); wait_done();
    send(18'd0, 1'b1, 68'd0); wait_done();

    // Bit-17 coefficient and sign handling
    set_rom(36'h20000, 36'd0, 36'd0, 36'd0);
    send(18'd3, 1'b1, 68'd393216); wait_done();
    set_rom(36'h3FFFF, 36'd0, 36'd0, 36'd0);
    send(18'h3FFFF, 1'b1, 68'h0 - 68'd262143); wait_done();

    // Signed extremes
    set_rom(36'h800000000, 36'd0, 36'd0, 36'd0);
    send(18'h20000, 1'b1, 68'd1 << 52); wait_done();
    set_rom(36'h7FFFFFFFF, 36'd0, 36'd0, 36'd0);
    send(18'h1FFFF, 1'b1, ((68'd1 << 35) - 68'd1) * ((68'd1 << 17) - 68'd1)); wait_done();

    // Overrun: valid held high, accepts every 10 cycles
    do_reset();
    set_rom(36'd1, 36'd2, 36'd3, 36'd4);
    for (int t = 0; t <= 31; t++) begin
      sample_valid = (t <= 30);
      sample_in    = 18'(100 + t);
      if (t % 10 == 0 && t <= 30) exp_q.push_back(ovr_exp[t / 10]);
      @(negedge clock);
      chk("ovr_ready", 68'(sample_ready), 68'(t % 10 == 0));
      chk("ovr_pulse", 68'(overrun), 68'(t > 0 && ((t - 1) % 10) != 0));
      tick();
    end
    sample_valid = 1'b0;
    wait_done();

    // Reset in the middle of RUN at tap k=2
    do_reset();
    send(18'd5, 1'b0, 68'd0);
    tick();
    @(negedge clock);
    chk("mid_run_mac_a", 68'(mac_a), 68'(5));
    chk("mid_run_mac_b", 68'(mac_b), 68'(1));
    tick();
    tick();
    @(negedge clock);
    chk("mid_run_busy", 68'(busy), 68'(1));
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 68'(busy), 68'(0));
    chk("mid_rst_ready", 68'(sample_ready), 68'(1));
    chk("mid_rst_mac_clr", 68'(mac_clr), 68'(1));
    chk("mid_rst_mac_a", 68'(mac_a), 68'(0));
    chk("mid_rst_mac_b", 68'(mac_b), 68'(0));
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk("mid_rst_no_valid", 68'(y_valid), 68'(0));
      tick();
    end
    send(18'd1, 1'b1, 68'd1); wait_done();
    send(18'd0, 1'b1, 68'd2); wait_done();
    send(18'd0, 1'b1, 68'd3); wait_done();
    send(18'd0, 1'b1, 68'd4); wait_done();

    // Wrap-around ramp with unit coefficients
    do_reset();
    set_rom(36'd1, 36'd1, 36'd1, 36'd1);
    for (int x = 1; x <= 9; x++) begin
      send(18'(x), 1'b1, ramp_exp[x - 1]);
      wait_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
